// File: rtl/fifopop_pkg.sv
// fifopop_pkg: shared definitions for the fifopop read-side controller.
//   FIFOPOP_BUF_DEPTH : number of entries in the output skid buffer (2).
//   cnt_t             : buffered-word count, 0..FIFOPOP_BUF_DEPTH.
package fifopop_pkg;
  localparam int FIFOPOP_BUF_DEPTH = 2;
  typedef logic [1:0] cnt_t;
endpackage

// File: rtl/fifopop_buf.sv
// fifopop_buf: 2-entry register buffer feeding the fifopop output stream.
// Strict FIFO order; out_data/out_valid are flops loaded from the next-state
// head so the downstream sees registered outputs with no bubble.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write a word at the tail
//   pop             : remove the head word (ignored when empty)
//   cnt             : number of buffered words
//   out_valid       : buffer non-empty (registered)
//   out_data        : head word (registered)
module fifopop_buf
  import fifopop_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output cnt_t          cnt,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem   [FIFOPOP_BUF_DEPTH];
  logic [DW-1:0] mem_n [FIFOPOP_BUF_DEPTH];
  logic          head, tail;
  logic          head_n, tail_n;
  cnt_t          cnt_n;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop & (cnt != '0);
    // A full buffer only takes a word when the head leaves in the same cycle.
    do_push = push & ((cnt != cnt_t'(FIFOPOP_BUF_DEPTH)) | do_pop);
    mem_n   = mem;
    if (do_push) mem_n[tail] = push_data;
    // Depth 2: pointer increment modulo 2 is a toggle.
    head_n  = head ^ do_pop;
    tail_n  = tail ^ do_push;
    cnt_n   = cnt + cnt_t'(do_push) - cnt_t'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFOPOP_BUF_DEPTH; i++) mem[i] <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      mem       <= mem_n;
      head      <= head_n;
      tail      <= tail_n;
      cnt       <= cnt_n;
      out_valid <= (cnt_n != '0);
      // Holding out_data when the buffer drains keeps it stable for free.
      if (cnt_n != '0) out_data <= mem_n[head_n];
    end
  end

endmodule

// File: rtl/fifopop.sv
// fifopop: read-side controller for a fifosync instance. Drains the FIFO
// through its one-cycle-latency read port and re-presents the words as a
// registered valid/ready stream at full throughput.
// Optional feature: define FIFOPOP_COUNT_EN to add the pop_count port.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   fifo_empty     : FIFO empty flag
//   fifo_rd_en     : FIFO read request (combinational)
//   fifo_rd_data   : FIFO read data, qualified by fifo_rd_valid
//   fifo_rd_valid  : FIFO read data valid, one cycle after fifo_rd_en
//   out_valid      : output word available (registered)
//   out_ready      : consumer accepts the word
//   out_data       : output word (registered)
//   pop_count      : words delivered, wraps mod 2^CW (FIFOPOP_COUNT_EN only)
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid is high, out_valid and out_data
// hold until that transfer happens; out_ready may change freely.
module fifopop
  import fifopop_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  input  logic          fifo_rd_valid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef FIFOPOP_COUNT_EN
  ,
  output logic [CW-1:0] pop_count
`endif
);

  cnt_t       cnt;
  logic       pop;
  logic       push;
  logic       inflight;
  logic       err;
  logic [2:0] occ;

  assign pop = out_valid & out_ready;

  // Words that will occupy the buffer after this edge: buffered plus the one
  // returning from last cycle's read, minus the one leaving now. out_ready
  // reaches fifo_rd_en through pop so a full buffer restarts immediately.
  assign occ        = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !rst & !fifo_empty & (occ < 3'(FIFOPOP_BUF_DEPTH));

  // Only returns we asked for are accepted; this also drops a stray return
  // right after reset, since inflight is cleared by reset.
  assign push = fifo_rd_valid & inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      err      <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_rd_valid & !inflight) err <= 1'b1;
    end
  end

  // err is a sticky status bit kept for debug visibility; nothing consumes it.
  logic unused_err;
  assign unused_err = err;

  fifopop_buf #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .cnt       (cnt),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

`ifdef FIFOPOP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) pop_count <= '0;
    else if (pop) pop_count <= pop_count + 1'b1;
  end
`else
  logic [CW-1:0] unused_cw;
  assign unused_cw = '0;
`endif

endmodule

// File: tb/tb_fifopop.sv
// tb_fifopop: directed bench for fifopop with a behavioural fifosync model,
// a per-cycle output model and an in-order scoreboard.
module tb_fifopop;
  localparam int DW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_valid = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef FIFOPOP_COUNT_EN
  logic [CW-1:0] pop_count;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fifopop #(.DW(DW), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_valid (fifo_rd_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
`ifdef FIFOPOP_COUNT_EN
    ,
    .pop_count     (pop_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- fifosync model ----------------
  logic [DW-1:0] fq[$];
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  int            preload_n = 0;
  logic          inject = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_rd_valid <= inject;
      fifo_rd_data  <= 16'hDEAD;
      fifo_empty    <= 1'b1;
    end else begin
      fifo_rd_valid <= 1'b0;
      if (fifo_rd_en && fq.size() != 0) begin
        fifo_rd_valid <= 1'b1;
        fifo_rd_data  <= fq.pop_front();
      end
      if (wr_en) fq.push_back(wr_data);
      for (int i = 0; i < preload_n; i++) fq.push_back(DW'(i));
      fifo_empty <= (fq.size() == 0);
    end
  end

  // ---------------- output model + scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] buf_m[$];
  int            inflight_m = 0;
  int            cnt_m = 0;
  int            pop_total = 0;
  logic          chk_en = 1'b0;

  always @(negedge clk) begin
    int   pop_m;
    logic exp_ov;
    logic exp_rd;
    if (chk_en) begin
      exp_ov = (buf_m.size() != 0);
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) check("out_data", 32'(out_data), 32'(buf_m[0]));
      pop_m  = (exp_ov && out_ready) ? 1 : 0;
      exp_rd = !rst && !fifo_empty && (buf_m.size() + inflight_m - pop_m < 2);
      check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
`ifdef FIFOPOP_COUNT_EN
      check("pop_count", pop_count, 32'(cnt_m));
`endif
      if (pop_m != 0) begin
        pop_total++;
        if (exp_q.size() == 0) check("stale_word", 32'(out_data), 32'hFFFF_FFFF);
        else check("order", 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (rst) begin
        buf_m.delete();
        inflight_m = 0;
        cnt_m      = 0;
      end else begin
        if (pop_m != 0) begin
          void'(buf_m.pop_front());
          cnt_m++;
        end
        if (fifo_rd_valid && inflight_m != 0) buf_m.push_back(fifo_rd_data);
        inflight_m = fifo_rd_en ? 1 : 0;
        check("occupancy_le2", 32'(buf_m.size() <= 2), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    out_ready = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(i));
    preload_n = n;
    tick();
    preload_n = 0;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    exp_q.push_back(d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_rd, first_ov, last_ov, ov_n, rd_n, gap, base;

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FIFOPOP_COUNT_EN
    check("rst_pop_count", pop_count, 32'd0);
`endif
    rst = 1'b0;
    chk_en = 1'b1;

    // Full drain, no stall
    out_ready = 1'b1;
    preload(16);
    first_rd = -1; first_ov = -1; last_ov = -1; ov_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      if (out_valid) begin
        if (first_ov < 0) first_ov = c;
        last_ov = c;
        ov_n++;
      end
    end
    check("drain_first_rd", 32'(first_rd), 32'd0);
    check("drain_latency", 32'(first_ov - first_rd), 32'd2);
    check("drain_words", 32'(ov_n), 32'd16);
    check("drain_no_gap", 32'(last_ov - first_ov), 32'd15);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef FIFOPOP_COUNT_EN
    check("count_16", pop_count, 32'd16);
`endif
    tick();

    // Backpressure
    do_reset(2);
`ifdef FIFOPOP_COUNT_EN
    check("count_after_rst", pop_count, 32'd0);
`endif
    out_ready = 1'b0;
    preload(8);
    rd_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_n++;
      if (out_valid) check("bp_hold", 32'(out_data), 32'd0);
    end
    check("bp_reads", 32'(rd_n), 32'd2);
    check("bp_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_restart_rd", 32'(fifo_rd_en), 32'd1);
    ov_n = 0; gap = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) ov_n++;
      else if (ov_n < 8) gap++;
    end
    check("bp_words", 32'(ov_n), 32'd8);
    check("bp_gaps", 32'(gap), 32'd0);
    tick();

    // Toggling ready
    do_reset(2);
    preload(16);
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      out_ready = ~out_ready;
      tick();
    end
    check("toggle_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty FIFO
    do_reset(2);
    out_ready = 1'b1;
    rd_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_n++;
    end
    check("empty_no_rd", 32'(rd_n), 32'd0);
    tick();
    write_word(16'hA5A5);
    ov_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) ov_n++;
    end
    check("empty_one_word", 32'(ov_n), 32'd1);
    check("empty_valid_low", 32'(out_valid), 32'd0);
    check("empty_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Reset mid-stream
    do_reset(2);
    out_ready = 1'b1;
    base = pop_total;
    preload(16);
    for (int c = 0; c < 40 && (pop_total - base) < 5; c++) tick();
    check("mid_delivered", 32'(pop_total - base), 32'd5);
    rst = 1'b1;
    out_ready = 1'b0;
    inject = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    inject = 1'b0;
    @(negedge clk);
    check("mid_ov_after_rst", 32'(out_valid), 32'd0);
`ifdef FIFOPOP_COUNT_EN
    check("mid_count_rst", pop_count, 32'd0);
`endif
    tick();
    out_ready = 1'b1;
    ov_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) ov_n++;
    end
    check("mid_no_stale", 32'(ov_n), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) write_word(16'h0100 + 16'(i));
    wait_drain("mid_resume", 30);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifopop.md
# fifopop

Read-side controller for the synchronous FIFO (`fifosync`). It drains the FIFO through its `rd_en`/`rd_data`/`rd_valid`/`empty` port, which has a one-cycle read latency. It re-presents the words as a valid/ready stream with full throughput and registered outputs. It sits between a `fifosync` instance and any downstream consumer that applies backpressure.

## Interface
- `DW`, default 16: data width; must match the FIFO's `DW`.
- `CW`, default 32: width of the pop counter (used only with `FIFOPOP_COUNT_EN`).
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_rd_en`, out, 1: read request to the FIFO (combinational).
- `fifo_rd_data`, in, DW: FIFO read data; valid when `fifo_rd_valid` is high.
- `fifo_rd_valid`, in, 1: FIFO read-data valid; arrives one cycle after `fifo_rd_en`.
- `out_valid`, out, 1: output word available (registered).
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, DW: output word (registered).
- `pop_count`, out, CW: words delivered downstream; present only with `FIFOPOP_COUNT_EN`.

## Operation
- Internal 2-entry output buffer; `cnt` holds the buffered count, 0..2.
- `inflight` flag marks a FIFO read issued last cycle whose data is not yet returned.
- `pop = out_valid & out_ready`.
- `fifo_rd_en = !rst & !fifo_empty & (cnt + inflight - pop < 2)`.
  - This rule guarantees the buffer never overflows.
  - There is a combinational path from `out_ready` to `fifo_rd_en`; this path is intentional.
- `inflight` is set to `fifo_rd_en` each cycle.
- Handling of `fifo_rd_valid`:
  - When high, `fifo_rd_data` is written to the buffer tail.
  - If `inflight` was 0, the word is discarded and `err` is set. `err` is an internal sticky flag that is cleared only by `rst`.
- Buffer order is strict FIFO.
  - `out_data` is always the head entry.
  - `out_valid = (cnt != 0)`.
  - `out_data` and `out_valid` are stable while `out_valid & !out_ready`.
- Simultaneous push and pop:
  - `cnt` is unchanged.
  - The head advances and the incoming word goes to the correct slot.
  - With `cnt` = 1, the incoming word becomes the new head on the next cycle.
- Reset values: `fifo_rd_en` = 0, `out_valid` = 0, `out_data` = 0, `cnt` = 0, `inflight` = 0, `pop_count` = 0.
- Reset mid-stream:
  - Buffered words and any in-flight return are dropped.
  - A `fifo_rd_valid` in the first cycle after `rst` falls is ignored.
  - The FIFO is expected to share the same `rst`.

## Timing
- Latency: `fifo_rd_en` high in cycle N gives `fifo_rd_valid` in N+1, and `out_valid` with that word in N+2.
- Throughput: 1 word/cycle sustained while `out_ready` = 1 and the FIFO is non-empty; no bubbles after the first word.
- Backpressure: with `out_ready` held low, at most 2 reads are issued. `fifo_rd_en` then stays 0 until a pop occurs.
- Restart: when `out_ready` rises with `cnt` = 2, a read is issued in that same cycle.
- Empty FIFO: `fifo_rd_en` stays 0. `out_valid` falls the cycle after the last buffered word pops.
- Wrap-around: the buffer index wraps modulo 2. With `FIFOPOP_COUNT_EN`, `pop_count` wraps modulo 2^CW.

## Configuration
- `FIFOPOP_COUNT_EN` defined: `pop_count` exists.
  - Increments by 1 on every `pop`.
  - Resets to 0.
  - Registered, so it reflects pops up to the previous cycle.
- `FIFOPOP_COUNT_EN` undefined: port and counter are absent, with no other behavioural change.

## Structure
- Shared package `fifopop_pkg`:
  - `FIFOPOP_BUF_DEPTH` = 2.
  - Count typedef, 2 bits.
- One sub-module, `fifopop_buf`: the 2-entry register buffer with push/pop, head/tail pointers, `cnt` and `out_valid`/`out_data`.
- Top level contains the issue logic, the `inflight` flag, `err`, and the optional counter.

## Test plan
- Full drain, no stall:
  - Stimulus: 16 words 0..15 preloaded in a `fifosync` (DW=16, AW=4); `out_ready` = 1.
  - Required: `out_data` 0..15 on 16 consecutive `out_valid` cycles, first word 2 cycles after the first `fifo_rd_en`.
- Backpressure:
  - Stimulus: 8 words preloaded; `out_ready` = 0 for 10 cycles, then 1.
  - Required: exactly 2 reads issued; `out_data` = 0 held stable; then 0..7 delivered in order without gaps.
- Toggling ready:
  - Stimulus: 16 words preloaded; `out_ready` toggles every cycle.
  - Required: 0..15 delivered in order, none lost or duplicated, and `cnt` never exceeds 2.
- Empty FIFO:
  - Stimulus: FIFO empty for 20 cycles, then 1 word `16'hA5A5` written.
  - Required: `fifo_rd_en` = 0 throughout the empty period; `16'hA5A5` appears once, then `out_valid` = 0.
- Reset mid-stream:
  - Stimulus: `rst` pulsed for 1 cycle after 5 of 16 words are delivered.
  - Required: `out_valid` = 0 in the cycle after reset; no stale word appears; the module resumes with newly written data.
- Counter (with `FIFOPOP_COUNT_EN`):
  - Stimulus: 16 words drained.
  - Required: `pop_count` = 16 one cycle after the last pop; `pop_count` = 0 after `rst`.
